dds_voice_scheduler: RTL and testbench

Sequencer and update arbiter for the time-multiplexed DDS voice pipeline. It generates the 4-phase `pipeline_state` / `voice_index` schedule that steps the shared `dds` datapath through every voice. It queues tuning-word update requests and issues them to the `dds` SPI-update port only in the safe pipeline slot. It also tags each `o_phase` sample from `dds` with its owning voice. It sits between the MIDI/SPI command decoder and the `dds` instance.

---
 rtl/dds_pkg.sv | 21 ++
 rtl/dds_req_fifo.sv | 50 +++++
 rtl/dds_voice_scheduler.sv | 168 ++++++++++++++++
 tb/tb_dds_voice_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and constants for the time-multiplexed DDS voice pipeline:
// pipeline state encoding, datapath widths and the tuning-update request record.
package dds_pkg;

  localparam int VOICE_W  = 8;
  localparam int TUNING_W = 32;
  localparam int PHASE_W  = 10;

  typedef enum logic [1:0] {
    ST_INC   = 2'd0,
    ST_CAPT  = 2'd1,
    ST_2     = 2'd2,
    ST_ISSUE = 2'd3
  } pipe_state_t;

  typedef struct packed {
    logic [VOICE_W-1:0]  voice;
    logic [TUNING_W-1:0] tuning;
  } dds_req_t;

endpackage

// File: rtl/dds_req_fifo.sv
// Synchronous circular-buffer FIFO of tuning requests. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
module dds_req_fifo
  import dds_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  dds_req_t                 wdata,
  output dds_req_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  dds_req_t    mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/dds_voice_scheduler.sv
// Voice sequencer and SPI-update arbiter for the shared dds datapath.
// Define DDS_SCHED_FIFO_EN for a FIFO_DEPTH-entry request queue; otherwise a single holding register.
module dds_voice_scheduler
  import dds_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_LAG  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [VOICE_W-1:0]  i_req_voice,
  input  logic [TUNING_W-1:0] i_req_tuning,
  output logic [1:0]          o_pipeline_state,
  output logic [VOICE_W-1:0]  o_voice_index,
  output logic                o_spi_flag,
  output logic [VOICE_W-1:0]  o_spi_voice_index,
  output logic [TUNING_W-1:0] o_spi_tuning_code,
  input  logic [PHASE_W-1:0]  i_phase,
  output logic                o_phase_valid,
  output logic [VOICE_W-1:0]  o_phase_voice,
  output logic [PHASE_W-1:0]  o_phase,
  output logic                o_frame_start,
  output logic                o_drop
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef DDS_SCHED_FIFO_EN
  localparam int QDEPTH = FIFO_DEPTH;
`else
  localparam int QDEPTH = 1;
`endif

  pipe_state_t         state_q, state_d;
  logic [VOICE_W-1:0]  voice_q, voice_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_INC;
      voice_q <= '0;
    end else begin
      state_q <= state_d;
      voice_q <= voice_d;
    end
  end

  always_comb begin
    state_d = state_q;
    voice_d = voice_q;
    case (state_q)
      ST_INC: begin
        state_d = ST_CAPT;
        voice_d = (voice_q == VOICE_W'(NUM_VOICES - 1)) ? '0 : voice_q + 1'b1;
      end
      ST_CAPT:  state_d = ST_2;
      ST_2:     state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_INC;
      default:  state_d = ST_INC;
    endcase
  end

  assign o_pipeline_state = state_q;
  assign o_voice_index    = voice_q;
  assign o_frame_start    = (state_q == ST_CAPT) && (voice_q == '0);

  // Handshake: a request transfers on any clock edge where i_req_valid and
  // o_req_ready are both high; the source holds its payload until then.
  dds_req_t            req_in;
  dds_req_t            head;
  logic                accept;
  logic                in_range;
  logic                push;
  logic                pop;
  logic                q_full;
  logic                q_empty;
  logic [CNT_W-1:0]    occ;
  logic [CNT_W-1:0]    occ_next;

  assign req_in   = {i_req_voice, i_req_tuning};
  assign accept   = i_req_valid && o_req_ready;
  assign in_range = ({1'b0, i_req_voice} < 9'(NUM_VOICES));
  assign push     = accept && in_range && !q_full;
  // Issuing only from registered queue state means a same-cycle push is never issued.
  assign pop      = (state_q == ST_ISSUE) && !q_empty && !i_reset;
  assign occ_next = occ + CNT_W'(push) - CNT_W'(pop);

`ifdef DDS_SCHED_FIFO_EN
  dds_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (i_clk),
    .reset (i_reset),
    .push  (push),
    .pop   (pop),
    .wdata (req_in),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty),
    .count (occ)
  );
`else
  dds_req_t hold_q;
  logic     hold_valid_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (push) begin
      hold_valid_q <= 1'b1;
      hold_q       <= req_in;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign head    = hold_q;
  assign q_full  = hold_valid_q;
  assign q_empty = !hold_valid_q;
  assign occ     = CNT_W'(hold_valid_q);
`endif

  dds_req_t           spi_q;
  logic [PHASE_W-1:0] phase_q;
  logic [VOICE_W-1:0] phase_voice_q;
  logic               phase_valid_q;
  logic               ready_q;
  logic               drop_q;
  logic [8:0]         lag_sum;
  logic [VOICE_W-1:0] phase_tag;

  // Bias by NUM_VOICES so the subtraction never goes negative before the modulo.
  assign lag_sum   = {1'b0, voice_q} + 9'(NUM_VOICES) - 9'(PHASE_LAG % NUM_VOICES);
  assign phase_tag = VOICE_W'(lag_sum % 9'(NUM_VOICES));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      spi_q         <= '0;
      phase_q       <= '0;
      phase_voice_q <= '0;
      phase_valid_q <= 1'b0;
      ready_q       <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      if (pop) spi_q <= head;
      if (state_q == ST_CAPT) begin
        phase_q       <= i_phase;
        phase_voice_q <= phase_tag;
      end
      phase_valid_q <= (state_q == ST_CAPT);
      ready_q       <= (occ_next != CNT_W'(QDEPTH));
      drop_q        <= accept && !in_range;
    end
  end

  // The strobe cycle presents the head directly; afterwards the captured copy holds.
  assign o_spi_flag        = pop;
  assign o_spi_voice_index = pop ? head.voice  : spi_q.voice;
  assign o_spi_tuning_code = pop ? head.tuning : spi_q.tuning;
  assign o_req_ready       = ready_q;
  assign o_drop            = drop_q;
  assign o_phase           = phase_q;
  assign o_phase_voice     = phase_voice_q;
  assign o_phase_valid     = phase_valid_q;

endmodule

// File: tb/tb_dds_voice_scheduler.sv
// Directed self-checking bench for dds_voice_scheduler (NUM_VOICES=8, PHASE_LAG=2),
// with expectations for both the holding-register and DDS_SCHED_FIFO_EN builds.
module tb_dds_voice_scheduler;

  localparam int NV = 8;
`ifdef DDS_SCHED_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_voice;
  logic [31:0] req_tuning;
  logic [1:0]  pipeline_state;
  logic [7:0]  voice_index;
  logic        spi_flag;
  logic [7:0]  spi_voice;
  logic [31:0] spi_tuning;
  logic [9:0]  phase_in;
  logic        phase_valid;
  logic [7:0]  phase_voice;
  logic [9:0]  phase_out;
  logic        frame_start;
  logic        drop;

  int          n_checks = 0;
  int          n_errors = 0;
  int          k;
  int          ri;
  logic [39:0] exp_q[$];
  int          acc_k[$];
  int          iss_k[$];
  int          exp_acc[5];
  int          exp_iss[5];

  dds_voice_scheduler #(
    .NUM_VOICES (NV),
    .PHASE_LAG  (2),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_req_valid       (req_valid),
    .o_req_ready       (req_ready),
    .i_req_voice       (req_voice),
    .i_req_tuning      (req_tuning),
    .o_pipeline_state  (pipeline_state),
    .o_voice_index     (voice_index),
    .o_spi_flag        (spi_flag),
    .o_spi_voice_index (spi_voice),
    .o_spi_tuning_code (spi_tuning),
    .i_phase           (phase_in),
    .o_phase_valid     (phase_valid),
    .o_phase_voice     (phase_voice),
    .o_phase           (phase_out),
    .o_frame_start     (frame_start),
    .o_drop            (drop)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s k=%0d got %0d exp %0d", tag, k, got, exp);
    end
  endtask

  function automatic int exp_voice(input int kk);
    return ((kk + 3) / 4) % NV;
  endfunction

  // scoreboard: accepted in-range requests must come out of the SPI port in order
  task automatic monitor();
    logic [39:0] e;
    if (req_valid && req_ready) begin
      acc_k.push_back(k);
      if (req_voice < NV) exp_q.push_back({req_voice, req_tuning});
    end
    if (spi_flag) begin
      iss_k.push_back(k);
      check_eq("issue_state", 32'(pipeline_state), 32'd3);
      if (exp_q.size() == 0) begin
        check_eq("spurious_issue", 32'(spi_flag), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("issue_voice", 32'(spi_voice), 32'(e[39:32]));
        check_eq("issue_tuning", spi_tuning, e[31:0]);
      end
    end
  endtask

  task automatic end_cycle();
    monitor();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic check_reset_values();
    check_eq("rst_state", 32'(pipeline_state), 32'd0);
    check_eq("rst_voice", 32'(voice_index), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_spi_flag", 32'(spi_flag), 32'd0);
    check_eq("rst_phase_valid", 32'(phase_valid), 32'd0);
    check_eq("rst_frame_start", 32'(frame_start), 32'd0);
    check_eq("rst_drop", 32'(drop), 32'd0);
    check_eq("rst_spi_voice", 32'(spi_voice), 32'd0);
    check_eq("rst_spi_tuning", spi_tuning, 32'd0);
    check_eq("rst_phase", 32'(phase_out), 32'd0);
    check_eq("rst_phase_voice", 32'(phase_voice), 32'd0);
  endtask

  // driver: idle inputs, then the phase input tracks the expected voice schedule
  task automatic drive_idle();
    req_valid  = 1'b0;
    req_voice  = '0;
    req_tuning = '0;
    phase_in   = 10'(100 + exp_voice(k));
  endtask

  initial begin
    if (FIFO) begin
      exp_acc = '{67, 68, 69, 70, 72};
    end else begin
      exp_acc = '{67, 72, 76, 80, 84};
    end
    exp_iss = '{71, 75, 79, 83, 87};

    k = 0;
    reset = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    k = 0;

    // schedule, frame pulses, phase tagging, single request at k=10, drop at k=20
    for (int i = 0; i < 64; i++) begin
      drive_idle();
      if (k == 10) begin
        req_valid = 1'b1; req_voice = 8'd5; req_tuning = 32'd1000000;
      end else if (k == 20) begin
        req_valid = 1'b1; req_voice = 8'd9; req_tuning = 32'd77;
      end
      @(negedge clk);
      if (k == 0) check_reset_values();
      check_eq("state", 32'(pipeline_state), 32'(k % 4));
      check_eq("voice", 32'(voice_index), 32'(exp_voice(k)));
      check_eq("frame_start", 32'(frame_start), 32'(k == 29 || k == 61));
      check_eq("drop", 32'(drop), 32'(k == 21));
      check_eq("spi_flag", 32'(spi_flag), 32'(k == 11));
      check_eq("phase_valid", 32'(phase_valid), 32'(k >= 2 && k % 4 == 2));
      if (k >= 2 && k % 4 == 2) begin
        check_eq("phase", 32'(phase_out), 32'(100 + exp_voice(k - 1)));
        check_eq("phase_voice", 32'(phase_voice), 32'((exp_voice(k - 1) + NV - 2) % NV));
      end
      if (k >= 11) begin
        check_eq("spi_hold_voice", 32'(spi_voice), 32'd5);
        check_eq("spi_hold_tuning", spi_tuning, 32'd1000000);
      end
      if (k == 1 || k == 10 || k == 12 || k == 20) check_eq("ready", 32'(req_ready), 32'd1);
      if (k == 11) check_eq("ready_after_accept", 32'(req_ready), 32'(FIFO));
      end_cycle();
    end

    // five back-to-back requests starting in a state-3 slot
    acc_k.delete();
    iss_k.delete();
    ri = 0;
    for (int i = 0; i < 28; i++) begin
      drive_idle();
      req_valid  = (k >= 67 && ri < 5);
      req_voice  = 8'(ri + 1);
      req_tuning = 32'h100 + 32'(ri);
      @(negedge clk);
      if (k == 71) check_eq("ready_when_full", 32'(req_ready), 32'd0);
      if (req_valid && req_ready) ri++;
      end_cycle();
    end
    check_eq("acc_count", 32'(acc_k.size()), 32'd5);
    check_eq("iss_count", 32'(iss_k.size()), 32'd5);
    for (int j = 0; j < 5; j++) begin
      check_eq("acc_cycle", (j < acc_k.size()) ? 32'(acc_k[j]) : 32'hFFFF_FFFF, 32'(exp_acc[j]));
      check_eq("iss_cycle", (j < iss_k.size()) ? 32'(iss_k[j]) : 32'hFFFF_FFFF, 32'(exp_iss[j]));
    end
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    // queue entries, then reset in a state-3 slot with work pending
    ri = 0;
    while (k < 99) begin
      drive_idle();
      req_valid  = (k >= 95 && ri < 3);
      req_voice  = 8'((ri + 6) % NV);
      req_tuning = 32'h200 + 32'(ri);
      @(negedge clk);
      if (k == 98) check_eq("queued_before_reset", 32'(exp_q.size()), FIFO ? 32'd3 : 32'd1);
      if (req_valid && req_ready) ri++;
      end_cycle();
    end
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    check_eq("reset_slot_state", 32'(pipeline_state), 32'd3);
    check_eq("flag_in_reset", 32'(spi_flag), 32'd0);
    end_cycle();
    @(negedge clk);
    end_cycle();
    exp_q.delete();
    reset = 1'b0;
    k = 0;

    // after release nothing is issued until a fresh request at k=40
    acc_k.delete();
    iss_k.delete();
    for (int i = 0; i < 61; i++) begin
      drive_idle();
      if (k == 40) begin
        req_valid = 1'b1; req_voice = 8'd3; req_tuning = 32'hABCD;
      end
      @(negedge clk);
      if (k == 0) check_reset_values();
      if (k == 1) check_eq("ready_after_reset", 32'(req_ready), 32'd1);
      check_eq("post_reset_flag", 32'(spi_flag), 32'(k == 43));
      end_cycle();
    end
    check_eq("post_reset_issues", 32'(iss_k.size()), 32'd1);
    check_eq("sb_final_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
